// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared state encoding and default geometry for reg_file_sweep
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - registered read port with zero-gate and optional write-first bypass
// Optional feature macro: RF_BYPASS_EN (write-first when defined, read-old otherwise).
module rf_read_port #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clearing,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] word,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] q
);

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic zero;
  logic hit;

  // wr_en is already qualified, so dropped writes and protected R0 never bypass
  always_comb begin
    zero = (ZERO_R0 != 0) && (addr == '0);
    hit  = BYPASS && wr_en && (addr == wr_addr);
  end

  always_ff @(posedge clk) begin
    if (rst || clearing || zero) begin
      q <= '0;
    end else if (hit) begin
      q <= wr_data;
    end else begin
      q <= word;
    end
  end

endmodule

// File: rtl/reg_file_sweep.sv
// rtl/reg_file_sweep.sv - parametrised register file with sweep clear and debug read port
// Optional feature macro: RF_BYPASS_EN (same-cycle write-first reads).
module reg_file_sweep
  import rf_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] DA,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] dbg_q,
  output logic              busy,
  output logic              wr_drop
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  rf_state_t         state;
  rf_state_t         state_next;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic r0_hit;
  logic wr_en;
  logic sweep_wr;
  logic busy_next;
  logic drop_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      ptr     <= '0;
      busy    <= 1'b1;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_next;
      busy    <= busy_next;
      wr_drop <= drop_next;
      if (state == RF_CLEAR) begin
        ptr <= ptr + ADDR_W'(1);
      end else if (clr) begin
        ptr <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RF_CLEAR: if (ptr == LAST) state_next = RF_RUN;
      RF_RUN:   if (clr)         state_next = RF_CLEAR;
      default:                   state_next = RF_CLEAR;
    endcase
  end

  // busy is loaded from the next-state decode so it is a clean flop output
  always_comb begin
    r0_hit    = (ZERO_R0 != 0) && (DA == '0);
    wr_en     = (state == RF_RUN) && !clr && we && !r0_hit;
    sweep_wr  = (state == RF_CLEAR);
    busy_next = (state_next == RF_CLEAR);
    drop_next = we && !wr_en;
  end

  // No reset on the array so it can map onto block RAM; the sweep clears it
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_wr) begin
        mem[ptr] <= '0;
      end else if (wr_en) begin
        mem[DA] <= data;
      end
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .clearing (sweep_wr),
    .addr     (AA),
    .word     (mem[AA]),
    .wr_en    (wr_en),
    .wr_addr  (DA),
    .wr_data  (data),
    .q        (a)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .clearing (sweep_wr),
    .addr     (BA),
    .word     (mem[BA]),
    .wr_en    (wr_en),
    .wr_addr  (DA),
    .wr_data  (data),
    .q        (b)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_port_dbg (
    .clk      (clk),
    .rst      (rst),
    .clearing (sweep_wr),
    .addr     (dbg_addr),
    .word     (mem[dbg_addr]),
    .wr_en    (wr_en),
    .wr_addr  (DA),
    .wr_data  (data),
    .q        (dbg_q)
  );

endmodule

// File: tb/tb_reg_file_sweep.sv
// tb/tb_reg_file_sweep.sv - directed scoreboard bench for reg_file_sweep (ZERO_R0=1, honours RF_BYPASS_EN)
module tb_reg_file_sweep;

  localparam int SEL_A    = 0;
  localparam int SEL_B    = 1;
  localparam int SEL_DBG  = 2;
  localparam int SEL_BUSY = 3;
  localparam int SEL_DROP = 4;

`ifdef RF_BYPASS_EN
  localparam logic [15:0] SAME_EDGE = 16'hBEEF;
`else
  localparam logic [15:0] SAME_EDGE = 16'h0001;
`endif

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] value;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        we;
  logic [2:0]  DA;
  logic [15:0] data;
  logic [2:0]  AA;
  logic [2:0]  BA;
  logic [2:0]  dbg_addr;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] dbg_q;
  logic        busy;
  logic        wr_drop;

  exp_t sb[$];
  int   applied = 0;
  int   misses  = 0;

  reg_file_sweep #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .we       (we),
    .DA       (DA),
    .data     (data),
    .AA       (AA),
    .BA       (BA),
    .dbg_addr (dbg_addr),
    .a        (a),
    .b        (b),
    .dbg_q    (dbg_q),
    .busy     (busy),
    .wr_drop  (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] observe(int sel);
    case (sel)
      SEL_A:    return a;
      SEL_B:    return b;
      SEL_DBG:  return dbg_q;
      SEL_BUSY: return {15'd0, busy};
      default:  return {15'd0, wr_drop};
    endcase
  endfunction

  function automatic void expect_out(string tag, int sel, logic [15:0] value);
    exp_t e;
    e.tag   = tag;
    e.sel   = sel;
    e.value = value;
    sb.push_back(e);
  endfunction

  task automatic tick();
    exp_t        e;
    logic [15:0] o;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      applied++;
      assert (o === e.value) else begin
        misses++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.value);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; DA = '0; data = '0;
    AA = '0; BA = '0; dbg_addr = '0;

    expect_out("rst_a", SEL_A, 16'h0);
    expect_out("rst_b", SEL_B, 16'h0);
    expect_out("rst_dbg", SEL_DBG, 16'h0);
    expect_out("rst_busy", SEL_BUSY, 16'h1);
    expect_out("rst_drop", SEL_DROP, 16'h0);
    tick();
    rst = 1'b0;

    // Initial sweep: write request on 3rd cycle, stray clr on 2nd cycle
    for (int i = 0; i < 8; i++) begin
      we = (i == 2); DA = 3'd4; data = 16'h5555; clr = (i == 1);
      expect_out($sformatf("sweep1_busy_%0d", i), SEL_BUSY, (i < 7) ? 16'h1 : 16'h0);
      expect_out($sformatf("sweep1_a_%0d", i), SEL_A, 16'h0);
      expect_out($sformatf("sweep1_b_%0d", i), SEL_B, 16'h0);
      if (i == 2) expect_out("busy_drop_pulse", SEL_DROP, 16'h1);
      if (i == 3) expect_out("busy_drop_end", SEL_DROP, 16'h0);
      tick();
    end
    we = 1'b0; clr = 1'b0;

    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      expect_out($sformatf("cleared_dbg_%0d", i), SEL_DBG, 16'h0);
      tick();
    end

    we = 1'b1; DA = 3'd3; data = 16'h1234;
    expect_out("r3_write_nodrop", SEL_DROP, 16'h0);
    tick();
    we = 1'b0; AA = 3'd3; BA = 3'd3;
    expect_out("r3_read_a", SEL_A, 16'h1234);
    expect_out("r3_read_b", SEL_B, 16'h1234);
    tick();

    we = 1'b1; DA = 3'd5; data = 16'h0001;
    tick();
    DA = 3'd5; data = 16'hBEEF; AA = 3'd5;
    expect_out("r5_same_edge", SEL_A, SAME_EDGE);
    tick();
    we = 1'b0;
    expect_out("r5_next_read", SEL_A, 16'hBEEF);
    tick();

    we = 1'b1; DA = 3'd0; data = 16'hFFFF; AA = 3'd0;
    expect_out("r0_drop_pulse", SEL_DROP, 16'h1);
    expect_out("r0_same_edge", SEL_A, 16'h0);
    tick();
    we = 1'b0; AA = 3'd0; BA = 3'd3; dbg_addr = 3'd5;
    expect_out("r0_drop_end", SEL_DROP, 16'h0);
    expect_out("r0_read", SEL_A, 16'h0);
    expect_out("r0_r3_kept", SEL_B, 16'h1234);
    expect_out("r0_r5_kept", SEL_DBG, 16'hBEEF);
    tick();

    we = 1'b1; DA = 3'd2; data = 16'h00AA;
    tick();
    we = 1'b0; AA = 3'd2;
    expect_out("r2_read", SEL_A, 16'h00AA);
    tick();

    // clr with a concurrent write: write dropped, sweep begins
    clr = 1'b1; we = 1'b1; DA = 3'd6; data = 16'h1111;
    expect_out("clr_busy", SEL_BUSY, 16'h1);
    expect_out("clr_drop", SEL_DROP, 16'h1);
    expect_out("clr_edge_read", SEL_A, 16'h00AA);
    tick();
    clr = 1'b0; we = 1'b0;

    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("sweep2_busy_%0d", i), SEL_BUSY, 16'h1);
      expect_out($sformatf("sweep2_a_%0d", i), SEL_A, 16'h0);
      if (i == 0) expect_out("clr_drop_end", SEL_DROP, 16'h0);
      tick();
    end

    rst = 1'b1;
    expect_out("rst2_busy", SEL_BUSY, 16'h1);
    expect_out("rst2_a", SEL_A, 16'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      expect_out($sformatf("sweep3_busy_%0d", i), SEL_BUSY, (i < 7) ? 16'h1 : 16'h0);
      tick();
    end

    AA = 3'd2; BA = 3'd3; dbg_addr = 3'd5;
    expect_out("post_clr_r2", SEL_A, 16'h0);
    expect_out("post_clr_r3", SEL_B, 16'h0);
    expect_out("post_clr_r5", SEL_DBG, 16'h0);
    tick();
    AA = 3'd6;
    expect_out("post_clr_r6", SEL_A, 16'h0);
    tick();

    we = 1'b1; DA = 3'd7; data = 16'h7777;
    expect_out("r7_write_nodrop", SEL_DROP, 16'h0);
    tick();
    we = 1'b0; AA = 3'd7; BA = 3'd7; dbg_addr = 3'd7;
    expect_out("r7_read_a", SEL_A, 16'h7777);
    expect_out("r7_read_b", SEL_B, 16'h7777);
    expect_out("r7_read_dbg", SEL_DBG, 16'h7777);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", applied, misses);
    $finish;
  end

endmodule
